// File: rtl/alu_result_sel_reg.sv
// alu_result_sel_reg: registered N_SRC-way ALU result select (src_bus/sel/in_valid/in_ready in, result/flag_z/flag_n/out_valid/out_ready out) with sticky err_sel cleared by clr_err
module alu_result_sel_reg #(
  parameter int WIDTH = 24,
  parameter int N_SRC = 8,
  parameter int SEL_W = 3,
  parameter logic [N_SRC-1:0] SRC_MASK = 8'b0010_0111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   flag_z,
  output logic                   flag_n,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_sel,
  input  logic                   clr_err
);
  localparam int NS = 1 << SEL_W;
  localparam logic [NS-1:0] MASK_EXT = NS'(SRC_MASK);
  logic [WIDTH-1:0] slots [NS];
  logic [WIDTH-1:0] sel_val;
  logic legal, acc;
  for (genvar i = 0; i < NS; i++) begin : g_slot
    if (i < N_SRC) begin : g_real
      assign slots[i] = MASK_EXT[i] ? src_bus[i*WIDTH +: WIDTH] : '0;
    end else begin : g_pad
      assign slots[i] = '0;
    end
  end
  assign legal    = MASK_EXT[sel];
  assign sel_val  = slots[sel];
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      flag_z    <= 1'b1;
      flag_n    <= 1'b0;
      out_valid <= 1'b0;
      err_sel   <= 1'b0;
    end else begin
      if (acc) begin
        result <= sel_val;
        flag_z <= sel_val == '0;
        flag_n <= sel_val[WIDTH-1];
      end
      out_valid <= acc || (out_valid && !out_ready);
      err_sel   <= (acc && !legal) || (err_sel && !clr_err);
    end
  end
endmodule

// File: tb/tb_alu_result_sel_reg.sv
// tb_alu_result_sel_reg: randomized and directed checks of alu_result_sel_reg against a behavioural model
module tb_alu_result_sel_reg;
  logic clk = 0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, err_sel, clr_err, flag_z, flag_n;
  logic [2:0] sel;
  logic [23:0] result;
  logic [23:0] src [8];
  logic [191:0] src_bus;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mask = 8'b0010_0111;
  logic [23:0] m_res;
  logic m_valid, m_err;
  always #5 clk = ~clk;
  always_comb begin
    src_bus = '0;
    for (int i = 0; i < 8; i++) src_bus[i*24 +: 24] = src[i];
  end
  alu_result_sel_reg dut (
    .clk(clk), .rst_n(rst_n), .src_bus(src_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .flag_z(flag_z), .flag_n(flag_n),
    .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel), .clr_err(clr_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_legal(input int s);
    return s < 8 && mask[s];
  endfunction
  task automatic cyc(input logic rn, input logic iv, input logic [2:0] s, input logic orr, input logic ce);
    logic rdy;
    rst_n = rn; in_valid = iv; sel = s; out_ready = orr; clr_err = ce;
    #1;
    rdy = !m_valid || orr;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (!rn) begin
      m_res = 0; m_valid = 0; m_err = 0;
    end else begin
      if (iv && rdy) begin
        m_res = is_legal(s) ? src[s] : 24'd0;
        m_valid = 1;
        if (!is_legal(s)) m_err = 1;
        else if (ce) m_err = 0;
      end else begin
        if (orr) m_valid = 0;
        if (ce) m_err = 0;
      end
    end
    #1;
    chk("result", result, m_res);
    chk("flag_z", flag_z, m_res == 0);
    chk("flag_n", flag_n, m_res[23]);
    chk("out_valid", out_valid, m_valid);
    chk("err_sel", err_sel, m_err);
  endtask
  initial begin
    m_res = 0; m_valid = 0; m_err = 0;
    for (int i = 0; i < 8; i++) src[i] = 24'(i * 24'h111111);
    cyc(0, 1, 2, 1, 0);
    cyc(0, 1, 2, 1, 0);
    chk("rst_result", result, 0);
    chk("rst_z", flag_z, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err_sel, 0);
    chk("rst_ready", in_ready, 1);
    src[2] = 24'h800001;
    cyc(1, 1, 2, 1, 0);
    chk("dir_res", result, 24'h800001);
    chk("dir_n", flag_n, 1);
    chk("dir_z", flag_z, 0);
    src[0] = 0;
    cyc(1, 1, 0, 1, 0);
    chk("dir_z0", flag_z, 1);
    cyc(1, 1, 1, 1, 0);
    chk("bp_res", result, src[1]);
    for (int k = 0; k < 3; k++) begin
      src[5] = 24'(k + 24'h400);
      cyc(1, 1, 5, 0, 0);
      chk("bp_hold", result, src[1]);
      chk("bp_ready", in_ready, 0);
    end
    cyc(1, 1, 5, 1, 0);
    chk("bp_load", result, src[5]);
    chk("bp_valid", out_valid, 1);
    src[3] = 24'hFFFFFF;
    cyc(1, 1, 3, 1, 0);
    chk("ill_res", result, 0);
    chk("ill_z", flag_z, 1);
    chk("ill_err", err_sel, 1);
    cyc(1, 1, 2, 1, 0);
    cyc(1, 1, 5, 1, 0);
    chk("ill_sticky", err_sel, 1);
    cyc(1, 0, 0, 1, 1);
    chk("clr", err_sel, 0);
    cyc(1, 1, 7, 1, 1);
    chk("collide", err_sel, 1);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_res", result, 0);
    chk("mid_err", err_sel, 0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++)
        src[i] = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
      cyc($urandom_range(0, 60) != 0, 1'($urandom), 3'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
